// File: rtl/tag_alloc_arbiter_pkg.sv
// Shared compute-unit package for the tag allocator.
//   NUM_TAGS, NUM_TAG_REQ : default pool size and requester count, also used by the
//                           dispatcher and the tag consumers.
//   tag_t, req_idx_t      : tag and requester index types at those defaults.
package tag_alloc_arbiter_pkg;

  localparam int unsigned NUM_TAGS    = 8;
  localparam int unsigned NUM_TAG_REQ = 4;

  localparam int unsigned TAG_WIDTH = $clog2(NUM_TAGS);
  localparam int unsigned REQ_WIDTH = $clog2(NUM_TAG_REQ);

  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [REQ_WIDTH-1:0] req_idx_t;

endpackage

// File: rtl/tag_alloc_arbiter_rr_pick.sv
// Round-robin first-eligible picker (purely combinational).
//   eligible_i : one bit per requester that may be granted this cycle
//   rr_i       : requester to consider first; search wraps NumReq-1 -> 0
//   gnt_o      : one-hot grant, '0 when nothing is eligible
//   idx_o      : index of the granted requester, '0 when nothing is eligible
module tag_alloc_rr_pick #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0]   eligible_i,
  input  logic [IdxWidth-1:0] rr_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (int'(rr_i) + k) % NumReq;
      if (!found && eligible_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/tag_alloc_arbiter.sv
// Tag pool allocator: shares NumTags in-flight tags between NumReq requesters with
// round-robin arbitration, a per-requester quota and at most one grant per cycle.
// The owner of each tag is recorded so a free (tag only) returns quota to the right requester.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i         : per-requester tag request
//   gnt_o, tag_o  : one-hot grant and granted tag, same cycle as req_i
//   free_valid_i  : return free_tag_i this cycle
//   num_free_o    : free tags in the pool (from registered state)
//   err_o         : one-cycle pulse after an illegal free when TAG_ALLOC_ARBITER_CHECKS_EN
//                   is defined; tied low otherwise
module tag_alloc_arbiter import tag_alloc_arbiter_pkg::*; #(
  parameter int unsigned NumTags   = NUM_TAGS,
  parameter int unsigned NumReq    = NUM_TAG_REQ,
  parameter int unsigned MaxPerReq = 4,
  parameter int unsigned TagWidth  = $clog2(NumTags),
  parameter int unsigned ReqWidth  = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [TagWidth-1:0] tag_o,
  input  logic                free_valid_i,
  input  logic [TagWidth-1:0] free_tag_i,
  output logic [TagWidth:0]   num_free_o,
  output logic                err_o
);

  localparam int unsigned CntWidth = $clog2(MaxPerReq + 1);
  localparam int unsigned NumW     = TagWidth + 1;

  logic [NumTags-1:0]  used_q, used_d;
  logic [ReqWidth-1:0] owner_q [NumTags];
  logic [ReqWidth-1:0] owner_d [NumTags];
  logic [CntWidth-1:0] cnt_q [NumReq];
  logic [CntWidth-1:0] cnt_d [NumReq];
  logic [ReqWidth-1:0] rr_q, rr_d;

  logic [TagWidth-1:0] free_idx;
  logic [NumW-1:0]     used_cnt;
  logic                pool_full;
  logic [NumReq-1:0]   eligible;
  logic [NumReq-1:0]   gnt;
  logic [ReqWidth-1:0] gnt_idx;
  logic                gnt_any;
  logic                free_hit;

  // Lowest-index free tag; scanning downwards lets the lowest index win.
  always_comb begin
    free_idx = '0;
    used_cnt = '0;
    for (int i = NumTags - 1; i >= 0; i--) begin
      if (!used_q[i]) free_idx = TagWidth'(i);
      used_cnt = used_cnt + NumW'(used_q[i]);
    end
  end

  assign pool_full = &used_q;

  always_comb begin
    eligible = '0;
    for (int r = 0; r < NumReq; r++) begin
      eligible[r] = req_i[r] && (cnt_q[r] < CntWidth'(MaxPerReq)) && !pool_full;
    end
  end

  tag_alloc_rr_pick #(
    .NumReq   (NumReq),
    .IdxWidth (ReqWidth)
  ) u_rr_pick (
    .eligible_i (eligible),
    .rr_i       (rr_q),
    .gnt_o      (gnt),
    .idx_o      (gnt_idx)
  );

  assign gnt_any    = |gnt;
  assign gnt_o      = gnt;
  assign tag_o      = gnt_any ? free_idx : '0;
  assign num_free_o = NumW'(NumTags) - used_cnt;
  assign free_hit   = free_valid_i && used_q[free_tag_i];

  // Free is applied before grant so a same-requester grant+free nets to zero. The two tags
  // never collide: the grant picks an unused tag, a legal free names a used one.
  always_comb begin
    used_d  = used_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (free_hit) begin
      used_d[free_tag_i]          = 1'b0;
      cnt_d[owner_q[free_tag_i]]  = cnt_d[owner_q[free_tag_i]] - CntWidth'(1);
    end
    if (gnt_any) begin
      used_d[free_idx]  = 1'b1;
      owner_d[free_idx] = gnt_idx;
      cnt_d[gnt_idx]    = cnt_d[gnt_idx] + CntWidth'(1);
      rr_d = (gnt_idx == ReqWidth'(NumReq - 1)) ? '0 : gnt_idx + ReqWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used_q <= '0;
      rr_q   <= '0;
      for (int i = 0; i < NumTags; i++) owner_q[i] <= '0;
      for (int r = 0; r < NumReq; r++) cnt_q[r] <= '0;
    end else begin
      used_q  <= used_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TAG_ALLOC_ARBITER_CHECKS_EN
  logic              err_q;
  logic [NumW-1:0]   cnt_sum;
  logic              cnt_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= free_valid_i && !used_q[free_tag_i];
  end

  assign err_o = err_q;

  always_comb begin
    cnt_sum = '0;
    cnt_ok  = 1'b1;
    for (int r = 0; r < NumReq; r++) begin
      cnt_sum = cnt_sum + NumW'(cnt_q[r]);
      if (cnt_q[r] > CntWidth'(MaxPerReq)) cnt_ok = 1'b0;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_cnt_sum:    assert property (@(posedge clk_i) disable iff (rst_i) used_cnt == cnt_sum);
  a_cnt_max:    assert property (@(posedge clk_i) disable iff (rst_i) cnt_ok);
`else
  assign err_o = 1'b0;
`endif

endmodule
